// File: rtl/t07_tft_sequencer.sv
// t07_tft_sequencer
// Issues a fixed TFT init sequence to an SPI TFT writer after reset. Once init
// is done, it arbitrates two requesters round-robin and forwards each captured
// command/parameter word to the writer. Every transfer is followed by at least
// one low spi_wi cycle.
//
// Ports
//   clk, nrst               clock; asynchronous active-low reset
//   req0_valid/addr/data    requester 0 (CPU) request, 32-bit command/parameter
//   req0_ready              combinational grant pulse; the word is captured on
//                           the next rising edge
//   req1_*                  the same for requester 1 (pixel source)
//   spi_wi                  write-initiate; held high until spi_ack or timeout
//   spi_address/spi_data    word presented to the writer, stable while spi_wi=1
//   spi_ack                 transfer complete; ignored while spi_wi=0
//   init_done               high once the DISPON command has completed
//   busy                    high in every state except IDLE
//   err                     sticky flag for an ack timeout
//   state_dbg               current FSM state, for observation only
//
// Handshake: a request word transfers on a rising edge where reqN_valid and
// reqN_ready are both high. Ready is only raised in IDLE after init, and only
// for the requester that wins arbitration. Valid may drop freely after that.
module t07_tft_sequencer #(
  parameter int DLY     = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        req0_valid,
  input  logic [31:0] req0_addr,
  input  logic [31:0] req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [31:0] req1_addr,
  input  logic [31:0] req1_data,
  output logic        req1_ready,
  output logic        spi_wi,
  output logic [31:0] spi_address,
  output logic [31:0] spi_data,
  input  logic        spi_ack,
  output logic        init_done,
  output logic        busy,
  output logic        err,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    INIT_ISSUE = 3'd0,
    INIT_DELAY = 3'd1,
    IDLE       = 3'd2,
    ISSUE      = 3'd3,
    GAP        = 3'd4
  } state_t;

  // One counter serves both the ack timeout and the init settle delay.
  localparam int MAXC = (TIMEOUT > DLY) ? TIMEOUT : DLY;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] DLY_LAST = CW'(DLY - 1);

  // Init table: {address, data}
  function automatic logic [63:0] init_entry(input logic [1:0] i);
    case (i)
      2'd0:    init_entry = {32'h0000_0001, 32'h0000_0000}; // SWRESET
      2'd1:    init_entry = {32'h0000_0011, 32'h0000_0000}; // SLPOUT
      2'd2:    init_entry = {32'h0000_003A, 32'h0000_0055}; // COLMOD
      default: init_entry = {32'h0000_0029, 32'h0000_0000}; // DISPON
    endcase
  endfunction

  state_t       state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [1:0]   idx, idx_n;
  logic         last_grant, last_grant_n;
  logic         init_done_n, err_n, wi_n;
  logic [31:0]  addr_n, data_n;
  logic         grant0, grant1, advance;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state       <= INIT_ISSUE;
      cnt         <= '0;
      idx         <= 2'd0;
      last_grant  <= 1'b1;
      init_done   <= 1'b0;
      err         <= 1'b0;
      spi_wi      <= 1'b0;
      spi_address <= 32'h0;
      spi_data    <= 32'h0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      idx         <= idx_n;
      last_grant  <= last_grant_n;
      init_done   <= init_done_n;
      err         <= err_n;
      spi_wi      <= wi_n;
      spi_address <= addr_n;
      spi_data    <= data_n;
    end
  end

  always_comb begin
    state_n      = state;
    cnt_n        = '0;
    idx_n        = idx;
    last_grant_n = last_grant;
    init_done_n  = init_done;
    err_n        = err;
    addr_n       = spi_address;
    data_n       = spi_data;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    advance      = 1'b0;
    // On a tie the requester that was not granted last wins.
    grant0 = req0_valid && (!req1_valid || last_grant);
    grant1 = req1_valid && (!req0_valid || !last_grant);

    case (state)
      INIT_ISSUE: begin
        // The first cycle after reset has spi_wi still low; wait for it.
        if (spi_wi) begin
          if (spi_ack) begin
            advance = 1'b1;
            state_n = (idx < 2'd2) ? INIT_DELAY : GAP;
          end else if (cnt == TO_LAST) begin
            advance = 1'b1;
            err_n   = 1'b1;
            state_n = GAP;
          end else begin
            cnt_n = cnt + 1'b1;
          end
          if (advance) begin
            idx_n = idx + 2'd1;
            if (idx == 2'd3) init_done_n = 1'b1;
          end
        end
      end
      INIT_DELAY: begin
        if (cnt == DLY_LAST) state_n = INIT_ISSUE;
        else                 cnt_n   = cnt + 1'b1;
      end
      IDLE: begin
        if (init_done && (grant0 || grant1)) begin
          req0_ready   = grant0;
          req1_ready   = grant1;
          addr_n       = grant0 ? req0_addr : req1_addr;
          data_n       = grant0 ? req0_data : req1_data;
          last_grant_n = grant1;
          state_n      = ISSUE;
        end
      end
      ISSUE: begin
        if (spi_ack) begin
          state_n = GAP;
        end else if (cnt == TO_LAST) begin
          err_n   = 1'b1;
          state_n = GAP;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      GAP:     state_n = init_done ? IDLE : INIT_ISSUE;
      default: state_n = INIT_ISSUE;
    endcase

    // Present the next table entry whenever an init write is (re)started.
    if (state_n == INIT_ISSUE) {addr_n, data_n} = init_entry(idx_n);
    // spi_wi is registered so it drops with reset and is glitch-free.
    wi_n = (state_n == ISSUE) || (state_n == INIT_ISSUE);
  end

  assign busy      = (state != IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_t07_tft_sequencer.sv
module tb_t07_tft_sequencer;
  localparam int DLY_T = 16;
  localparam int TO_T  = 64;
  localparam int W     = 64;

  logic        clk = 1'b0;
  logic        nrst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [31:0] req0_addr = '0, req0_data = '0, req1_addr = '0, req1_data = '0;
  logic        req0_ready, req1_ready;
  logic        spi_wi, spi_ack = 1'b0;
  logic [31:0] spi_address, spi_data;
  logic        init_done, busy, err;
  logic [2:0]  state_dbg;

  t07_tft_sequencer #(.DLY(DLY_T), .TIMEOUT(TO_T)) dut (
    .clk(clk), .nrst(nrst),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .spi_wi(spi_wi), .spi_address(spi_address), .spi_data(spi_data), .spi_ack(spi_ack),
    .init_done(init_done), .busy(busy), .err(err), .state_dbg(state_dbg)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  initial begin
    #900000;
    $display("FAIL watchdog: run did not end, state_dbg=%0d", state_dbg);
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];      // words expected on spi_address/spi_data, in order
  int           exp_gap_q[$];  // expected low-wi lengths between init writes
  int           tb_last = 1;   // round-robin reference: last granted requester

  // ---------------- SPI writer model ----------------
  // Acks ack_lat cycles into a write (0 = never). With spur_en it also
  // raises stray acks while spi_wi is low, which must be ignored.
  int ack_lat = 3;
  int lat_cur = 0;
  int hi_cnt  = 0;
  bit spur_en = 1'b0;

  always begin
    @(posedge clk); #1;
    if (!nrst) begin
      hi_cnt  = 0;
      spi_ack = 1'b0;
    end else if (spi_wi) begin
      hi_cnt++;
      if (hi_cnt == 1) lat_cur = ack_lat;
      spi_ack = (lat_cur != 0) && (hi_cnt == lat_cur);
    end else begin
      hi_cnt  = 0;
      spi_ack = spur_en ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  // ---------------- transfer monitor ----------------
  logic         prev_wi = 1'b0;
  logic [63:0]  cur_w;
  bit           stable, have_fall;
  int           hi_len, lo_len;

  always @(negedge clk) begin
    if (!nrst) begin
      prev_wi   = 1'b0;
      have_fall = 1'b0;
      hi_len    = 0;
      lo_len    = 0;
    end else begin
      if (spi_wi && !prev_wi) begin
        if (have_fall && exp_gap_q.size() > 0) check("init_gap_len", lo_len, exp_gap_q.pop_front());
        cur_w  = {spi_address, spi_data};
        stable = 1'b1;
        hi_len = 1;
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_xfer: got 0x%0h, expected no transfer", cur_w);
        end else begin
          check("xfer_word", cur_w, exp_q.pop_front());
        end
      end else if (spi_wi) begin
        hi_len++;
        if ({spi_address, spi_data} !== cur_w) stable = 1'b0;
      end else if (prev_wi) begin
        check("wi_stable", stable, 1);
        check("wi_high_len", hi_len, (lat_cur == 0) ? TO_T : lat_cur);
        have_fall = 1'b1;
        lo_len    = 1;
      end else begin
        lo_len++;
      end
      prev_wi = spi_wi;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_reset(input bit chk);
    nrst = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    if (chk) begin
      check("rst_wi", spi_wi, 0);
      check("rst_addr", spi_address, 0);
      check("rst_data", spi_data, 0);
      check("rst_init_done", init_done, 0);
      check("rst_err", err, 0);
      check("rst_busy", busy, 1);
      check("rst_ready0", req0_ready, 0);
      check("rst_ready1", req1_ready, 0);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    exp_q.delete();
    exp_gap_q.delete();
    tb_last = 1;
    repeat (3) @(posedge clk);
    #1 nrst = 1'b1;
  endtask

  task automatic run_init(input int lat, input bit hold_req, input bit spur);
    int cyc = 0, viol = 0, busyv = 0;
    ack_lat = lat;
    spur_en = spur;
    exp_q.push_back({32'h01, 32'h0});
    exp_q.push_back({32'h11, 32'h0});
    exp_q.push_back({32'h3A, 32'h55});
    exp_q.push_back({32'h29, 32'h0});
    exp_gap_q.push_back(DLY_T);
    exp_gap_q.push_back(DLY_T);
    exp_gap_q.push_back(1);
    if (hold_req) begin
      req0_valid = 1'b1; req0_addr = 32'h40; req0_data = 32'h4444;
      req1_valid = 1'b1; req1_addr = 32'h50; req1_data = 32'h5555;
    end
    while (cyc < 500 && !init_done) begin
      tick(); #2;
      cyc++;
      if (!init_done && (req0_ready || req1_ready)) viol++;
      if (!busy) busyv++;
    end
    check("init_finished", init_done, 1);
    check("ready_during_init", viol, 0);
    check("busy_during_init", busyv, 0);
    check("init_words_left", exp_q.size(), 0);
    check("wi_low_after_dispon", spi_wi, 0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    spur_en = 1'b0;
    tick();
    check("idle_after_init_gap", busy, 0);
    check("init_done_holds", init_done, 1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit          v0;
    logic [31:0] a0, d0;
    bit          v1;
    logic [31:0] a1, d1;
    int          lat;
    int          exp_g;
    logic [31:0] exp_a, exp_d;
  } vec_t;

  vec_t vt[10];

  // Presents one request from IDLE and follows it through ISSUE and GAP.
  task automatic apply_vec(input vec_t v);
    int g = -1, cyc = 0, gapc = 0;
    ack_lat    = v.lat;
    req0_valid = v.v0; req0_addr = v.a0; req0_data = v.d0;
    req1_valid = v.v1; req1_addr = v.a1; req1_data = v.d1;
    while (g < 0 && cyc < 50) begin
      #2;
      if (req0_ready && req1_ready) g = 2;
      else if (req0_ready)          g = 0;
      else if (req1_ready)          g = 1;
      if (g < 0) begin tick(); cyc++; end
    end
    check("vec_grant", g, v.exp_g);
    if (g == 0 || g == 1) begin
      exp_q.push_back({v.exp_a, v.exp_d});
      tb_last = g;
    end
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check("vec_wi_next_cycle", spi_wi, 1);
    check("vec_word_on_bus", {spi_address, spi_data}, {v.exp_a, v.exp_d});
    cyc = 0;
    while (busy && cyc < TO_T + 40) begin
      tick(); cyc++;
      if (!spi_wi && busy) gapc++;
    end
    check("vec_back_to_idle", busy, 0);
    check("vec_gap_cycles", gapc, 1);
  endtask

  // ---------------- random phase ----------------
  logic [63:0] src0_q[$], src1_q[$];

  task automatic random_phase();
    int cyc = 0, g, expg;
    bit h0, h1;
    repeat ($urandom_range(10, 20)) src0_q.push_back({$urandom, $urandom});
    repeat ($urandom_range(10, 20)) src1_q.push_back({$urandom, $urandom});
    spur_en = 1'b1;
    while ((src0_q.size() > 0 || src1_q.size() > 0 || req0_valid || req1_valid) && cyc < 4000) begin
      if (!req0_valid && src0_q.size() > 0 && $urandom_range(0, 1) == 1) begin
        req0_valid = 1'b1; {req0_addr, req0_data} = src0_q[0];
      end
      if (!req1_valid && src1_q.size() > 0 && $urandom_range(0, 1) == 1) begin
        req1_valid = 1'b1; {req1_addr, req1_data} = src1_q[0];
      end
      ack_lat = $urandom_range(1, 4);
      h0 = 1'b0; h1 = 1'b0;
      #2;
      if (req0_ready || req1_ready) begin
        g    = (req0_ready && req1_ready) ? 2 : (req0_ready ? 0 : 1);
        expg = (req0_valid && req1_valid) ? (tb_last == 1 ? 0 : 1) : (req0_valid ? 0 : 1);
        check("rr_grant", g, expg);
        if (g == 0) begin
          exp_q.push_back({req0_addr, req0_data});
          void'(src0_q.pop_front());
          tb_last = 0; h0 = 1'b1;
        end else if (g == 1) begin
          exp_q.push_back({req1_addr, req1_data});
          void'(src1_q.pop_front());
          tb_last = 1; h1 = 1'b1;
        end
      end
      tick(); cyc++;
      if (h0) req0_valid = 1'b0;
      if (h1) req1_valid = 1'b0;
    end
    cyc = 0;
    while (busy && cyc < 200) begin tick(); cyc++; end
    spur_en = 1'b0;
    check("rand_sources_drained", src0_q.size() + src1_q.size(), 0);
    check("rand_all_words_sent", exp_q.size(), 0);
    check("rand_idle", busy, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int cyc, g, order;
    int k0, k1;

    vt[0] = '{1'b1, 32'hA5, 32'h1234,     1'b0, 32'h0,  32'h0,        3, 0, 32'hA5, 32'h1234};
    vt[1] = '{1'b1, 32'h10, 32'hAAAA0001, 1'b1, 32'h20, 32'hBBBB0001, 1, 1, 32'h20, 32'hBBBB0001};
    vt[2] = '{1'b1, 32'h11, 32'hAAAA0002, 1'b1, 32'h21, 32'hBBBB0002, 2, 0, 32'h11, 32'hAAAA0002};
    vt[3] = '{1'b1, 32'h12, 32'hAAAA0003, 1'b1, 32'h22, 32'hBBBB0003, 4, 1, 32'h22, 32'hBBBB0003};
    vt[4] = '{1'b0, 32'h0,  32'h0,        1'b1, 32'h23, 32'hBBBB0004, 1, 1, 32'h23, 32'hBBBB0004};
    vt[5] = '{1'b1, 32'h13, 32'hAAAA0005, 1'b1, 32'h24, 32'hBBBB0005, 2, 0, 32'h13, 32'hAAAA0005};
    vt[6] = '{1'b1, 32'h14, 32'hAAAA0006, 1'b0, 32'h0,  32'h0,        5, 0, 32'h14, 32'hAAAA0006};
    vt[7] = '{1'b1, 32'h15, 32'hAAAA0007, 1'b1, 32'h25, 32'hBBBB0007, 3, 1, 32'h25, 32'hBBBB0007};
    // no ack: times out (req0 only after req1 won last)
    vt[8] = '{1'b1, 32'h77, 32'hDEAD,     1'b0, 32'h0,  32'h0,        0, 0, 32'h77, 32'hDEAD};
    // served normally after the timeout
    vt[9] = '{1'b0, 32'h0,  32'h0,        1'b1, 32'h78, 32'hBEEF,     2, 1, 32'h78, 32'hBEEF};

    #1;
    pulse_reset(1'b1);
    run_init(3, 1'b0, 1'b0);

    for (int i = 0; i < 8; i++) apply_vec(vt[i]);

    check("err_before_timeout", err, 0);
    apply_vec(vt[8]);
    check("err_after_timeout", err, 1);
    apply_vec(vt[9]);
    check("err_sticky", err, 1);

    // Reset while a transfer is held in ISSUE.
    ack_lat = 0;
    req0_valid = 1'b1; req0_addr = 32'h99; req0_data = 32'h1;
    #2;
    check("rst_test_grant", req0_ready, 1);
    exp_q.push_back({32'h99, 32'h1});
    tick();
    req0_valid = 1'b0;
    repeat (4) tick();
    check("rst_test_in_issue", spi_wi, 1);
    #3 nrst = 1'b0;
    #1;
    check("rst_mid_wi", spi_wi, 0);
    check("rst_mid_init_done", init_done, 0);
    check("rst_mid_busy", busy, 1);
    pulse_reset(1'b1);
    run_init(2, 1'b1, 1'b1);

    // Both requesters held valid: grants must alternate starting with req0.
    ack_lat = 2;
    order = 0; k0 = 0; k1 = 0; cyc = 0;
    req0_valid = 1'b1; req0_addr = 32'h60; req0_data = 32'h600;
    req1_valid = 1'b1; req1_addr = 32'h70; req1_data = 32'h700;
    for (int n = 0; n < 4; ) begin
      #2;
      g = -1;
      if (req0_ready) begin g = 0; exp_q.push_back({req0_addr, req0_data}); end
      else if (req1_ready) begin g = 1; exp_q.push_back({req1_addr, req1_data}); end
      tick(); cyc++;
      if (g == 0) begin k0++; req0_addr = 32'h60 + k0; req0_data = 32'h600 + k0; end
      if (g == 1) begin k1++; req1_addr = 32'h70 + k1; req1_data = 32'h700 + k1; end
      if (g >= 0) begin order = (order << 2) | g; tb_last = g; n++; end
      if (cyc > 200) break;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check("tie_grant_order", order, 32'h11);
    cyc = 0;
    while (busy && cyc < 100) begin tick(); cyc++; end
    check("tie_idle", busy, 0);

    random_phase();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/t07_tft_sequencer.md
T07_TFT_SEQUENCER -- requirements
Module: t07_tft_sequencer

Interface
REQ-001 Parameter: DLY, 16, settle cycles inserted after the SWRESET and SLPOUT init commands.
REQ-002 Parameter: TIMEOUT, 1024, maximum cycles to wait for spi_ack before aborting a transfer.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 nrst  input  1  reset; asynchronous, active-low.
REQ-005 req0_valid  input  1  requester 0 (CPU) transfer request.
REQ-006 req0_addr / req0_data  input  32 / 32  requester 0 command word / parameter word.
REQ-007 req0_ready  output  1  one-cycle pulse: requester 0 word captured.
REQ-008 req1_valid, req1_addr, req1_data, req1_ready  same widths and meaning for requester 1 (pixel source).
REQ-009 spi_wi  output  1  write-initiate to the SPI TFT writer.
REQ-010 spi_address / spi_data  output  32 / 32  command / parameter presented to the SPI TFT writer.
REQ-011 spi_ack  input  1  SPI TFT writer transfer-complete.
REQ-012 init_done  output  1  high once the init sequence has completed.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 err  output  1  sticky: an ack timeout has occurred.

Function
REQ-015 States: INIT_ISSUE, INIT_DELAY, IDLE, ISSUE, GAP.
REQ-016 Init table, fixed, in order (address/data): 0x01/0 (SWRESET) + DLY delay; 0x11/0 (SLPOUT) + DLY delay; 0x3A/0x55 (COLMOD); 0x29/0 (DISPON).
REQ-017 INIT_ISSUE: drive table entry on spi_address/spi_data with spi_wi=1; on spi_ack=1 go to INIT_DELAY (DLY-flagged entry) or GAP, advance index.
REQ-018 INIT_DELAY: spi_wi=0, count DLY cycles exactly, then INIT_ISSUE with next entry.
REQ-019 After the DISPON ack: init_done=1 from the next cycle, remains 1 until reset; next state GAP then IDLE.
REQ-020 Requests are ignored (ready=0) while init_done=0.
REQ-021 IDLE: if any reqN_valid, grant per REQ-022, capture addr/data into output registers, pulse reqN_ready for exactly that cycle, enter ISSUE.
REQ-022 Arbitration round-robin: single valid wins; both valid -> requester not granted last; last_grant resets to 1 (req0 wins first tie).
REQ-023 ISSUE: spi_wi=1, spi_address/spi_data held stable until spi_ack sampled high; then GAP.
REQ-024 GAP: spi_wi=0 for exactly one cycle, then IDLE (or INIT_ISSUE during init); guarantees a low wi cycle between consecutive transfers.
REQ-025 Latency: valid in IDLE -> spi_wi high next cycle; back-to-back grants minimum 1 (ack) + 1 (GAP) + 1 (IDLE) cycles apart.
REQ-026 Timeout counter clears on entry to ISSUE/INIT_ISSUE; reaching TIMEOUT cycles without spi_ack -> drop spi_wi, set err, go to GAP; init index still advances (init completes).
REQ-027 spi_ack while spi_wi=0 is ignored.
REQ-028 reqN_valid deasserted after capture has no effect on the in-flight transfer.
REQ-029 spi_ack and a new request in the same cycle: ack processed; request waits until IDLE.

Reset
REQ-030 nrst low: immediately state=INIT_ISSUE, init index=0, spi_wi=0, spi_address=0, spi_data=0, req0_ready=req1_ready=0, init_done=0, err=0, last_grant=1, counters=0.
REQ-031 Reset asserted mid-transfer aborts it; after release the init sequence restarts from SWRESET.
REQ-032 busy=1 throughout reset release until init completes.

Verification
REQ-033 Reset release, spi_ack returned 3 cycles after each wi rise -> commands 0x01,0x11,0x3A(0x55),0x29 in order; wi low exactly DLY cycles after 0x01 and 0x11; init_done rises after 0x29.
REQ-034 After init, req0 addr 0xA5/data 0x1234 -> req0_ready one-cycle pulse, spi_wi next cycle with 0xA5/0x1234 stable until ack, one low-wi GAP cycle.
REQ-035 Both requesters held valid for 4 transfers -> grant order req0,req1,req0,req1.
REQ-036 spi_ack never returned -> spi_wi drops after TIMEOUT cycles, err=1 and stays 1, next request still served.
REQ-037 nrst pulsed low while ISSUE active -> spi_wi=0 and init_done=0 same cycle, SWRESET reissued after release.
REQ-038 reqN_valid during init -> no ready pulse until init_done=1.
